// File: rtl/div_iter_u_pkg.sv
// rtl/div_iter_u_pkg.sv - FSM encoding and parameter legality check for the iterative divider
package div_iter_u_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic bit params_ok(input int data_width, input int bits_per_cycle);
    return (data_width >= 8) && (data_width % 2 == 0) &&
           (bits_per_cycle == 1 || bits_per_cycle == 2 || bits_per_cycle == 4) &&
           (data_width % bits_per_cycle == 0);
  endfunction

endpackage

// File: rtl/div_iter_u_step.sv
// rtl/div_iter_u_step.sv - one combinational restoring shift-subtract step
module div_iter_u_step #(
  parameter int W = 64
) (
  input  logic [W:0]   rem_in,
  input  logic         numer_bit,
  input  logic [W-1:0] denom,
  output logic [W:0]   rem_out,
  output logic         q_bit
);

  logic [W+1:0] rem_sh;

  // Compare on the full shifted value so rem_in[W] participates; the result always fits in W+1 bits.
  assign rem_sh  = {rem_in, numer_bit};
  assign q_bit   = (rem_sh >= {2'b00, denom});
  assign rem_out = rem_sh[W:0] - ({1'b0, denom} & {(W + 1){q_bit}});

endmodule

// File: rtl/div_iter_u.sv
// rtl/div_iter_u.sv - iterative unsigned divider with valid/ready handshake and divide-by-zero flag
module div_iter_u
  import div_iter_u_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] numer_sig,
  input  logic [DATA_WIDTH-1:0] denom_sig,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient_sig,
  output logic [DATA_WIDTH-1:0] remain_sig,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam int N     = DATA_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0]      LAST         = CNT_W'(N - 1);
  localparam logic [DATA_WIDTH-1:0] DBZ_QUOTIENT = '1;

  if (!params_ok(DATA_WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
    $error("div_iter_u: illegal DATA_WIDTH/BITS_PER_CYCLE combination");
  end

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DATA_WIDTH-1:0]   numer_q;
  logic [DATA_WIDTH-1:0]   denom_q;
  logic [DATA_WIDTH:0]     rem_q;
  logic [DATA_WIDTH-1:0]   quot_q;
  logic                    dbz_q;
  logic [DATA_WIDTH:0]     rem_next;
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic                    accept;
  logic                    denom_zero;

  assign accept     = in_valid & in_ready;
  assign denom_zero = (denom_sig == '0);

  // Step i consumes numerator bit W-1-i, so quotient bits land MSB first.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    logic [DATA_WIDTH:0] rem_i;
    logic [DATA_WIDTH:0] rem_o;
    if (i == 0) begin : g_first
      assign rem_i = rem_q;
    end else begin : g_next
      assign rem_i = g_step[i-1].rem_o;
    end
    div_iter_u_step #(.W(DATA_WIDTH)) u_step (
      .rem_in    (rem_i),
      .numer_bit (numer_q[DATA_WIDTH-1-i]),
      .denom     (denom_q),
      .rem_out   (rem_o),
      .q_bit     (q_bits[BITS_PER_CYCLE-1-i])
    );
  end

  assign rem_next = g_step[BITS_PER_CYCLE-1].rem_o;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = denom_zero ? ST_DONE : ST_CALC;
      end
      ST_CALC: begin
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q   <= '0;
      numer_q <= '0;
      denom_q <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            numer_q <= numer_sig;
            denom_q <= denom_sig;
            cnt_q   <= '0;
            dbz_q   <= denom_zero;
            // Zero divisor reuses the legacy encoding: all-ones quotient, numerator as remainder.
            if (denom_zero) begin
              quot_q <= DBZ_QUOTIENT;
              rem_q  <= {1'b0, numer_sig};
            end else begin
              quot_q <= '0;
              rem_q  <= '0;
            end
          end
        end
        ST_CALC: begin
          numer_q <= numer_q << BITS_PER_CYCLE;
          rem_q   <= rem_next;
          quot_q  <= {quot_q[DATA_WIDTH-BITS_PER_CYCLE-1:0], q_bits};
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_DONE: begin
          if (out_ready) dbz_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient_sig = quot_q;
  assign remain_sig   = rem_q[DATA_WIDTH-1:0];
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_div_iter_u.sv
// tb/tb_div_iter_u.sv - scoreboard bench driving BITS_PER_CYCLE = 1, 2 and 4 dividers in lockstep
`timescale 1ns/1ps
module tb_div_iter_u;

  localparam int W = 64;
  localparam logic [63:0] ONES = '1;
  // A zero divisor goes straight to DONE on the accept edge itself.
  localparam int LAT_DBZ = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          acc;
  } exp_t;

  typedef struct {
    logic [63:0] n;
    logic [63:0] d;
    logic [63:0] q;
    logic [63:0] r;
    logic        z;
  } vec_t;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] numer_sig = '0;
  logic [63:0] denom_sig = '0;
  logic [2:0]  in_ready_v, out_valid_v, dbz_v, busy_v;
  logic [63:0] q_v [3];
  logic [63:0] r_v [3];

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int BPC = 1 << g;
    localparam int LAT = W / BPC;

    div_iter_u #(.DATA_WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready_v[g]),
      .numer_sig    (numer_sig),
      .denom_sig    (denom_sig),
      .out_valid    (out_valid_v[g]),
      .out_ready    (out_ready),
      .quotient_sig (q_v[g]),
      .remain_sig   (r_v[g]),
      .div_by_zero  (dbz_v[g]),
      .busy         (busy_v[g])
    );

    int   rd_idx     = 0;
    logic prev_valid = 1'b0;

    always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
        rd_idx     <= exp_q.size();
        prev_valid <= 1'b0;
      end else begin
        if (out_valid_v[g] && !prev_valid) begin
          if (rd_idx < exp_q.size())
            check("latency", g, 64'(cyc - exp_q[rd_idx].acc),
                  exp_q[rd_idx].dbz ? 64'(LAT_DBZ) : 64'(LAT));
          else
            check("unexpected_out_valid", g, 64'(out_valid_v[g]), 64'd0);
        end
        if (out_valid_v[g] && out_ready && rd_idx < exp_q.size()) begin
          check("quotient", g, q_v[g], exp_q[rd_idx].q);
          check("remainder", g, r_v[g], exp_q[rd_idx].r);
          check("div_by_zero", g, 64'(dbz_v[g]), 64'(exp_q[rd_idx].dbz));
          rd_idx <= rd_idx + 1;
        end
        prev_valid <= out_valid_v[g];
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < 3; g++) begin
      check({tag, "_in_ready"}, g, 64'(in_ready_v[g]), 64'd1);
      check({tag, "_out_valid"}, g, 64'(out_valid_v[g]), 64'd0);
      check({tag, "_busy"}, g, 64'(busy_v[g]), 64'd0);
      check({tag, "_div_by_zero"}, g, 64'(dbz_v[g]), 64'd0);
      check({tag, "_quotient"}, g, q_v[g], 64'd0);
      check({tag, "_remainder"}, g, r_v[g], 64'd0);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (in_ready_v !== 3'b111 && t < 300) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (t >= 300) check(name, -1, 64'(in_ready_v), 64'd7);
  endtask

  task automatic issue(input logic [63:0] n, input logic [63:0] d,
                       input logic [63:0] eq, input logic [63:0] er, input logic edbz);
    wait_idle("idle_before_issue");
    exp_q.push_back('{q: eq, r: er, dbz: edbz, acc: cyc + 1});
    in_valid  = 1'b1;
    numer_sig = n;
    denom_sig = d;
    @(posedge sys_clk); #1;
    in_valid  = 1'b0;
    numer_sig = {$urandom, $urandom};
    denom_sig = {$urandom, $urandom};
  endtask

  vec_t vecs [13];

  initial begin
    int t;
    vecs = '{
      '{64'hFFFF_FFFF,           64'd50_000_000,        64'd85,               64'd44_967_295,        1'b0},
      '{ONES,                    64'd1,                 ONES,                 64'd0,                 1'b0},
      '{64'd7,                   64'd9,                 64'd0,                64'd7,                 1'b0},
      '{64'd1234,                64'd0,                 ONES,                 64'd1234,              1'b1},
      '{64'd100,                 64'd7,                 64'd14,               64'd2,                 1'b0},
      '{ONES,                    ONES,                  64'd1,                64'd0,                 1'b0},
      '{ONES,                    64'h8000_0000_0000_0000, 64'd1,              64'h7FFF_FFFF_FFFF_FFFF, 1'b0},
      '{64'd0,                   64'd5,                 64'd0,                64'd0,                 1'b0},
      '{64'd0,                   64'd0,                 ONES,                 64'd0,                 1'b1},
      '{ONES,                    64'd0,                 ONES,                 ONES,                  1'b1},
      '{64'd1_000_000_007,       64'd1000,              64'd1_000_000,        64'd7,                 1'b0},
      '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF,         64'h1_0000_0000,      64'hFFFF_FFFE,         1'b0},
      '{64'd1,                   ONES,                  64'd0,                64'd1,                 1'b0}
    };

    #23;
    check_reset_vals("reset");
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].z);
      wait_idle("op_complete");
    end

    // Backpressure: hold out_ready low and poke in_valid while results are waiting.
    out_ready = 1'b0;
    issue(64'hFFFF_FFFF, 64'd50_000_000, 64'd85, 64'd44_967_295, 1'b0);
    t = 0;
    while (out_valid_v !== 3'b111 && t < 300) begin
      @(posedge sys_clk); #1;
      t++;
    end
    if (t >= 300) check("bp_wait_valid", -1, 64'(out_valid_v), 64'd7);
    for (int i = 0; i < 10; i++) begin
      in_valid  = i[0];
      numer_sig = 64'd5;
      denom_sig = 64'd1;
      @(negedge sys_clk);
      check("bp_quotient_stable", 0, q_v[0], 64'd85);
      check("bp_remainder_stable", 0, r_v[0], 64'd44_967_295);
      check("bp_in_ready", -1, 64'(in_ready_v), 64'd0);
      check("bp_busy", -1, 64'(busy_v), 64'd7);
      check("bp_out_valid", -1, 64'(out_valid_v), 64'd7);
      @(posedge sys_clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge sys_clk); #1;
    check("bp_release_in_ready", -1, 64'(in_ready_v), 64'd7);
    check("bp_release_out_valid", -1, 64'(out_valid_v), 64'd0);
    check("bp_release_busy", -1, 64'(busy_v), 64'd0);
    check("bp_release_dbz", -1, 64'(dbz_v), 64'd0);

    // Reset twenty iterations into a long operation, then run a clean one.
    issue(ONES, 64'd3, 64'h5555_5555_5555_5555, 64'd0, 1'b0);
    repeat (20) @(posedge sys_clk);
    #3;
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    @(posedge sys_clk); #1;
    check_reset_vals("midop_reset_hold");
    #2;
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    issue(64'd1000, 64'd10, 64'd100, 64'd0, 1'b0);
    wait_idle("post_reset_op");
    @(posedge sys_clk); #1;

    check("drained", 0, 64'(g_dut[0].rd_idx), 64'(exp_q.size()));
    check("drained", 1, 64'(g_dut[1].rd_idx), 64'(exp_q.size()));
    check("drained", 2, 64'(g_dut[2].rd_idx), 64'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
